// File: rtl/fcvt_wu_s.sv
// FP32 -> unsigned 32-bit converter (FCVT.WU.S). The operand is classified at accept,
// denormalised by an iterative shifter, then rounded and saturated in a single ROUND cycle.
module fcvt_wu_s #(
    parameter int SHIFT_STEP = 4
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out,
    output logic [4:0]  fflags
);
    typedef enum logic [1:0] {IDLE, SHIFT, ROUND, DONE} state_t;

    localparam logic [4:0] STEP5 = 5'(SHIFT_STEP);

    state_t      r_state;
    logic [31:0] r_int;
    logic        r_g, r_s;
    logic [4:0]  r_cnt;
    logic        r_left, r_sign, r_spec, r_nv;
    logic [2:0]  r_rm;

    logic        w_unused_rs2;
    assign w_unused_rs2 = ^rs2[31:3];

    // Accept-time classification
    logic [7:0]  w_exp;
    logic [22:0] w_frac;
    logic        w_sign;
    logic [31:0] w_ld_int;
    logic        w_ld_g, w_ld_s, w_ld_left, w_ld_spec, w_ld_nv;
    logic [4:0]  w_ld_cnt;

    assign w_exp  = rs1[30:23];
    assign w_frac = rs1[22:0];
    assign w_sign = rs1[31];

    // Exponent thresholds in biased form: e>=32 <=> exp>=159, e>=0 <=> exp>=127, e>=23 <=> exp>=150.
    always_comb begin
        w_ld_int  = {8'd0, (w_exp != 8'd0), w_frac};
        w_ld_g    = 1'b0;
        w_ld_s    = 1'b0;
        w_ld_cnt  = 5'd0;
        w_ld_left = 1'b0;
        w_ld_spec = 1'b0;
        w_ld_nv   = 1'b0;
        if (w_exp == 8'hFF && w_frac != 23'd0) begin
            w_ld_spec = 1'b1; w_ld_nv = 1'b1; w_ld_int = 32'hFFFF_FFFF;
        end else if (!w_sign && w_exp >= 8'd159) begin
            w_ld_spec = 1'b1; w_ld_nv = 1'b1; w_ld_int = 32'hFFFF_FFFF;
        end else if (w_sign && w_exp >= 8'd127) begin
            w_ld_spec = 1'b1; w_ld_nv = 1'b1; w_ld_int = 32'd0;
        end else if (w_exp == 8'd0 && w_frac == 23'd0) begin
            w_ld_spec = 1'b1; w_ld_int = 32'd0;
        end else if (w_exp < 8'd127) begin
            w_ld_int = 32'd0;
            w_ld_g   = (w_exp == 8'd126);
            w_ld_s   = (w_exp == 8'd126) ? (w_frac != 23'd0) : 1'b1;
        end else if (w_exp >= 8'd150) begin
            w_ld_left = 1'b1;
            w_ld_cnt  = 5'(w_exp - 8'd150);
        end else begin
            w_ld_cnt  = 5'(8'd150 - w_exp);
        end
    end

    // One SHIFT cycle: move k = min(cnt, SHIFT_STEP) bits
    logic [4:0]  w_k;
    logic [31:0] w_sh_int;
    logic        w_sh_g, w_sh_s;

    assign w_k = (r_cnt < STEP5) ? r_cnt : STEP5;

    always_comb begin
        w_sh_int = r_int;
        w_sh_g   = r_g;
        w_sh_s   = r_s;
        if (r_left) begin
            w_sh_int = r_int << w_k;
        end else begin
            for (int i = 0; i < SHIFT_STEP; i++) begin
                if (5'(i) < w_k) begin
                    w_sh_s   = w_sh_s | w_sh_g;
                    w_sh_g   = w_sh_int[0];
                    w_sh_int = w_sh_int >> 1;
                end
            end
        end
    end

    // Rounding and sign handling
    logic        w_gs, w_inc;
    logic [31:0] w_sum, w_rnd_out;
    logic [4:0]  w_rnd_flags;

    assign w_gs  = r_g | r_s;
    assign w_sum = r_int + {31'd0, w_inc};

    always_comb begin
        case (r_rm)
            3'd0:    w_inc = r_g & (r_s | r_int[0]);
            3'd2:    w_inc = r_sign & w_gs;
            3'd3:    w_inc = ~r_sign & w_gs;
            3'd4:    w_inc = r_g;
            default: w_inc = 1'b0;
        endcase
    end

    always_comb begin
        w_rnd_out   = 32'd0;
        w_rnd_flags = 5'd0;
        if (r_spec) begin
            w_rnd_out   = r_int;
            w_rnd_flags = {r_nv, 4'd0};
        end else if (!r_sign) begin
            w_rnd_out   = w_sum;
            w_rnd_flags = {4'd0, w_gs};
        end else if (w_sum == 32'd0) begin
            w_rnd_flags = {4'd0, w_gs};
        end else begin
            w_rnd_flags = 5'b10000;
        end
    end

    assign in_ready = (r_state == IDLE);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= IDLE;
            r_int     <= 32'd0;
            r_g       <= 1'b0;
            r_s       <= 1'b0;
            r_cnt     <= 5'd0;
            r_left    <= 1'b0;
            r_sign    <= 1'b0;
            r_spec    <= 1'b0;
            r_nv      <= 1'b0;
            r_rm      <= 3'd0;
            out       <= 32'd0;
            fflags    <= 5'd0;
            out_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (in_valid) begin
                    r_int   <= w_ld_int;
                    r_g     <= w_ld_g;
                    r_s     <= w_ld_s;
                    r_cnt   <= w_ld_cnt;
                    r_left  <= w_ld_left;
                    r_sign  <= w_sign;
                    r_spec  <= w_ld_spec;
                    r_nv    <= w_ld_nv;
                    r_rm    <= rs2[2:0];
                    r_state <= (w_ld_spec || w_ld_cnt == 5'd0) ? ROUND : SHIFT;
                end
                SHIFT: begin
                    r_int <= w_sh_int;
                    r_g   <= w_sh_g;
                    r_s   <= w_sh_s;
                    r_cnt <= r_cnt - w_k;
                    if (r_cnt == w_k) r_state <= ROUND;
                end
                ROUND: begin
                    out       <= w_rnd_out;
                    fflags    <= w_rnd_flags;
                    out_valid <= 1'b1;
                    r_state   <= DONE;
                end
                DONE: if (out_ready) begin
                    out_valid <= 1'b0;
                    r_state   <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_fcvt_wu_s.sv
// Directed bench for fcvt_wu_s: expected results are queued at issue and compared when out_valid rises.
module tb_fcvt_wu_s;
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] rs1 = 32'd0;
    logic [31:0] rs2 = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out;
    logic [4:0]  fflags;

    int nerr = 0;
    int nchk = 0;
    logic [36:0] sb[$];

    fcvt_wu_s #(.SHIFT_STEP(4)) dut (
        .clk(clk), .resetn(resetn), .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .fflags(fflags)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one operand and wait for the accept edge; optionally queue the expectation.
    task automatic issue(input logic [31:0] a, input logic [2:0] rm, input logic push,
                         input logic [31:0] eo, input logic [4:0] ef);
        int n = 0;
        while (!in_ready && n < 100) begin @(posedge clk); #1; n++; end
        check("issue_ready", {31'd0, in_ready}, 32'd1);
        rs1 = a;
        rs2 = {29'($urandom()), rm};
        in_valid = 1'b1;
        if (push) sb.push_back({eo, ef});
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Wait for out_valid (edges counted after the accept edge), then compare against the queue head.
    task automatic collect(input string tag, output int lat);
        logic [36:0] e;
        lat = 0;
        while (!out_valid && lat < 200) begin @(posedge clk); #1; lat++; end
        check({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
        if (sb.size() == 0) begin
            nchk++; nerr++;
            $error("FAIL %s_sb: observed empty queue expected entry", tag);
        end else begin
            e = sb.pop_front();
            check({tag, "_out"}, out, e[36:5]);
            check({tag, "_flags"}, {27'd0, fflags}, {27'd0, e[4:0]});
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic op(input string tag, input logic [31:0] a, input logic [2:0] rm,
                      input logic [31:0] eo, input logic [4:0] ef);
        int lat;
        issue(a, rm, 1'b1, eo, ef);
        collect(tag, lat);
        consume();
    endtask

    initial begin
        int lat;
        logic [31:0] held_out;
        logic [4:0]  held_fl;

        #12;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out", out, 32'd0);
        check("rst_flags", {27'd0, fflags}, 32'd0);
        check("rst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;

        // 1.0 RNE: cnt=23 -> six shift cycles, out_valid after accept+7 edges
        issue(32'h3F800000, 3'd0, 1'b1, 32'd1, 5'd0);
        collect("one", lat);
        check("one_lat", lat, 32'd7);
        consume();

        op("2p5_rne", 32'h40200000, 3'd0, 32'd2, 5'b00001);
        op("2p5_rtz", 32'h40200000, 3'd1, 32'd2, 5'b00001);
        op("2p5_rup", 32'h40200000, 3'd3, 32'd3, 5'b00001);
        op("2p5_rmm", 32'h40200000, 3'd4, 32'd3, 5'b00001);
        op("2p5_rm7", 32'h40200000, 3'd7, 32'd2, 5'b00001);
        op("0p5_rne", 32'h3F000000, 3'd0, 32'd0, 5'b00001);
        op("1p5_rne", 32'h3FC00000, 3'd0, 32'd2, 5'b00001);

        issue(32'h4F7FFFFF, 3'd0, 1'b1, 32'hFFFFFF00, 5'd0);
        collect("maxf", lat);
        check("maxf_lat", lat, 32'd3);
        consume();
        op("two32", 32'h4F800000, 3'd0, 32'hFFFFFFFF, 5'b10000);
        op("nan",   32'h7FC00000, 3'd0, 32'hFFFFFFFF, 5'b10000);
        op("pinf",  32'h7F800000, 3'd0, 32'hFFFFFFFF, 5'b10000);
        op("ninf",  32'hFF800000, 3'd0, 32'd0, 5'b10000);
        op("nzero", 32'h80000000, 3'd0, 32'd0, 5'd0);

        op("neg1",     32'hBF800000, 3'd1, 32'd0, 5'b10000);
        op("nq_rtz",   32'hBE800000, 3'd1, 32'd0, 5'b00001);
        op("nq_rdn",   32'hBE800000, 3'd2, 32'd0, 5'b10000);
        op("denorm",   32'h00000001, 3'd3, 32'd1, 5'b00001);
        op("big_exact", 32'h4B800001, 3'd0, 32'h01000002, 5'd0);

        // Backpressure: 2.5 RUP held while out_ready=0, pulsed in_valid must be ignored
        issue(32'h40200000, 3'd3, 1'b1, 32'd3, 5'b00001);
        collect("bp", lat);
        held_out = out;
        held_fl  = fflags;
        for (int i = 0; i < 5; i++) begin
            rs1 = 32'h41200000;
            in_valid = (i == 2);
            @(posedge clk); #1;
            check("bp_out", out, held_out);
            check("bp_flags", {27'd0, fflags}, {27'd0, held_fl});
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_ready", {31'd0, in_ready}, 32'd0);
        end
        in_valid = 1'b0;
        consume();
        check("bp_idle", {31'd0, in_ready}, 32'd1);
        check("bp_drop", {31'd0, out_valid}, 32'd0);
        check("bp_keep", out, 32'd3);
        issue(32'h41200000, 3'd0, 1'b1, 32'd10, 5'd0);
        check("bp_accept", {31'd0, in_ready}, 32'd0);
        collect("ten", lat);
        consume();

        // Async reset mid-SHIFT
        op("pre_rst", 32'h4F7FFFFF, 3'd0, 32'hFFFFFF00, 5'd0);
        issue(32'h3F800000, 3'd0, 1'b0, 32'd0, 5'd0);
        @(posedge clk); #3;
        resetn = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_out", out, 32'd0);
        check("arst_flags", {27'd0, fflags}, 32'd0);
        check("arst_ready", {31'd0, in_ready}, 32'd1);
        @(negedge clk); resetn = 1'b1;
        @(posedge clk); #1;
        op("post_rst", 32'h41200000, 3'd0, 32'h0000000A, 5'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/fcvt_wu_s.md
Name: fcvt_wu_s

Overview:
Multi-cycle FP32 to unsigned-32 converter implementing RISC-V FCVT.WU.S, the inverse of the existing unsigned-int-to-float path. It sits in the float execute cluster behind a valid/ready handshake. It denormalises the significand with an iterative shifter, rounds per the instruction's rounding mode, and saturates with RISC-V invalid/inexact flags.

Parameters:
SHIFT_STEP, 4, maximum bit positions shifted per SHIFT cycle (1..8).

Ports:
clk  in  1  clock, all state updates on the rising edge
resetn  in  1  asynchronous active-low reset
in_valid  in  1  operand valid
in_ready  out  1  high only in IDLE; a transfer occurs when in_valid && in_ready
rs1  in  32  FP32 operand
rs2  in  32  bits [2:0] = rm (0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 treated as RTZ); other bits ignored
out_valid  out  1  result valid, held until consumed
out_ready  in  1  consumer accept
out  out  32  unsigned integer result
fflags  out  5  {NV,DZ,OF,UF,NX}; DZ, OF and UF are always 0

Behaviour:
- Reset (async, any state): state=IDLE, out=0, fflags=0, out_valid=0, shift registers cleared. Any in-flight operation is discarded.
- States and transitions:
  - IDLE -> SHIFT or ROUND on accept.
  - SHIFT -> ROUND when the remaining count reaches 0.
  - ROUND -> DONE.
  - DONE -> IDLE on out_ready.
- Accept edge: latch rm, sign, e = exp-127 and m = {exp!=0, frac} (24 bits). Classify the operand:
  - NaN: result 0xFFFFFFFF, NV.
  - +inf, or positive with e>=32: 0xFFFFFFFF, NV.
  - -inf, or negative with e>=0: 0, NV.
  - Zero (either sign): 0, no flags.
  - e<0, including denormals: integer part=0; guard = (e==-1); sticky = (e==-1) ? frac!=0 : operand nonzero.
  - 23<=e<=31: left shift, cnt = e-23.
  - 0<=e<=22: right shift, cnt = 23-e. Bits shifted out feed guard (last bit out) and sticky (OR of all earlier bits out).
- Special cases and cnt=0 go straight to ROUND.
- SHIFT: each cycle shifts min(cnt, SHIFT_STEP) bits and decrements cnt by the same amount. Data is held in a 32-bit integer register plus guard/sticky bits.
- ROUND: compute inc:
  - RNE: g && (s || lsb)
  - RTZ: 0
  - RDN: sign && (g||s)
  - RUP: !sign && (g||s)
  - RMM: g
- Sign rules in ROUND:
  - Positive: out = int+inc; NX = g||s.
  - Negative with int+inc==0 and g||s: out=0, NX.
  - Negative with int+inc!=0: out=0, NV only (no NX).
- Rounding cannot carry past bit 31, because rounding only occurs when e<=22.
- ROUND edge registers out and fflags and sets out_valid=1.
- DONE:
  - out, fflags and out_valid are held stable while out_ready=0.
  - On out_ready: out_valid<=0 and return to IDLE; out and fflags keep their last values.
  - in_ready is 0, so in_valid is ignored.
- Latency: accept at edge N; out_valid is high after edge N+1+ceil(cnt/SHIFT_STEP). Throughput is one op per latency+1 cycles at minimum, since there is no overlap.
- in_valid asserted while busy is not consumed; the source must hold it until in_ready.

Test Plan:
1. 0x3F800000 (1.0), RNE, STEP=4 -> out=0x00000001, fflags=0. cnt=23, so out_valid rises after edge N+7.
2. 0x40200000 (2.5):
   - RNE -> 2, NX.
   - RTZ -> 2, NX.
   - RUP -> 3, NX.
   - RMM -> 3, NX.
   - Also 0x3F000000 (0.5) RNE -> 0, NX; 0x3FC00000 (1.5) RNE -> 2, NX.
3. Boundary and saturation:
   - 0x4F7FFFFF -> 0xFFFFFF00, fflags=0, 2 SHIFT cycles.
   - 0x4F800000 (2^32) -> 0xFFFFFFFF, NV.
   - 0x7FC00000 (NaN) -> 0xFFFFFFFF, NV.
   - 0x7F800000 (+inf) -> 0xFFFFFFFF, NV.
   - 0xFF800000 (-inf) -> 0, NV.
   - 0x80000000 (-0) -> 0, no flags.
4. Negative inputs:
   - 0xBF800000 (-1.0) -> 0, NV.
   - 0xBE800000 (-0.25) RTZ -> 0, NX.
   - 0xBE800000 (-0.25) RDN -> 0, NV.
   - 0x00000001 (denormal) RUP -> 1, NX.
5. Backpressure:
   - Hold out_ready=0 for 5 cycles after out_valid; out and fflags must stay stable, in_ready=0, and a pulsed in_valid is not accepted.
   - Then out_ready=1: IDLE on the next edge, and the next operand is accepted on the following edge.
6. Async reset:
   - Assert resetn=0 mid-SHIFT on 1.0 -> immediately out_valid=0, out=0, fflags=0, in_ready=1.
   - After release, 0x41200000 (10.0) converts to 0x0000000A with no stale data.
